// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data port: funct3 codes, FSM states and access checks.
// Misalignment checking is only used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Stores only have signed-width codes; unsigned variants exist for loads only.
  function automatic logic lsu_funct3_legal(input logic is_store, input logic [2:0] funct3);
    logic sized;
    sized = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    if (is_store) return sized;
    return sized || (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_format.sv
// Store formatting: byte enables and zero-masked write data derived from funct3.
module lsu_store_format
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata
);

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    case (funct3)
      F3_B: begin
        mem_be    = 4'b0001;
        mem_wdata = {24'h0, wdata[7:0]};
      end
      F3_H: begin
        mem_be    = 4'b0011;
        mem_wdata = {16'h0, wdata[15:0]};
      end
      F3_W: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store initiator for the unified memory data port: IDLE -> ACCESS -> RESP, one request at a time.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module lsu_data_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic                  mem_re,
  output logic [2:0]            mem_load_type,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  load_count,
  output logic [CNT_WIDTH-1:0]  store_count
);

  import lsu_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  lsu_state_e            state_q, state_d;
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req_ok;
  logic [3:0]            fmt_be;
  logic [DATA_WIDTH-1:0] fmt_wdata;

  lsu_store_format u_store_format (
    .funct3    (funct3_q),
    .wdata     (wdata_q),
    .mem_be    (fmt_be),
    .mem_wdata (fmt_wdata)
  );

  always_comb begin
    req_ok = lsu_funct3_legal(req_is_store, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (lsu_misaligned(req_funct3, req_addr[1:0])) req_ok = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Memory strobes decode purely from state, so an async reset kills them at once.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    mem_be        = 4'b0000;
    mem_re        = 1'b0;
    mem_load_type = 3'b000;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_ok ? ST_ACCESS : ST_RESP;
      end
      ST_ACCESS: begin
        mem_addr = addr_q;
        if (is_store_q) begin
          mem_we    = 1'b1;
          mem_be    = fmt_be;
          mem_wdata = fmt_wdata;
        end else begin
          mem_re        = 1'b1;
          mem_load_type = funct3_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      load_count  <= '0;
      store_count <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_err   <= !req_ok;
            resp_rdata <= '0;
          end
        end
        ST_ACCESS: begin
          resp_err <= 1'b0;
          if (is_store_q) begin
            resp_rdata  <= '0;
            store_count <= store_count + CNT_ONE;
          end else begin
            resp_rdata <= mem_rdata;
            load_count <= load_count + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed self-checking bench for lsu_data_port with a byte-addressed memory model.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic        mem_re;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_rdata;
  logic [31:0] load_count;
  logic [31:0] store_count;

  logic [7:0]  mem [0:1023];
  int cmp_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  lsu_data_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be),
    .mem_re(mem_re), .mem_load_type(mem_load_type), .mem_rdata(mem_rdata),
    .load_count(load_count), .store_count(store_count)
  );

  // Memory model: NOP-filled words, synchronous byte-enabled write at byte granularity.
  initial begin
    for (int i = 0; i < 1024; i += 4) begin
      mem[i] = 8'h13; mem[i+1] = 8'h00; mem[i+2] = 8'h00; mem[i+3] = 8'h00;
    end
    forever begin
      @(posedge clk);
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[(mem_addr[9:0] + 10'(b))] = mem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    logic [9:0] a;
    logic [7:0] b0, b1, b2, b3;
    a  = mem_addr[9:0];
    b0 = mem[a]; b1 = mem[a + 10'd1]; b2 = mem[a + 10'd2]; b3 = mem[a + 10'd3];
    case (mem_load_type)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b100:  mem_rdata = {24'h0, b0};
      3'b101:  mem_rdata = {16'h0, b1, b0};
      default: mem_rdata = {b3, b2, b1, b0};
    endcase
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a request and return one step after the accepting edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int waited = 0;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
    while (!req_ready && waited < 20) begin step(); waited++; end
    cmp_count++;
    if (req_ready !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL issue_ready: got %b expected 1 within 20 cycles", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    cmp_count += 8;
    if (req_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL rst_req_ready: got %b expected 1", req_ready); end
    if (resp_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    if (resp_err !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_resp_err: got %b expected 0", resp_err); end
    if (resp_rdata !== 32'h0) begin fail_count++; $display("[TB] FAIL rst_rdata: got %h expected 0", resp_rdata); end
    if (load_count !== 32'h0) begin fail_count++; $display("[TB] FAIL rst_load_count: got %0d expected 0", load_count); end
    if (store_count !== 32'h0) begin fail_count++; $display("[TB] FAIL rst_store_count: got %0d expected 0", store_count); end
    if ({mem_we, mem_re} !== 2'b00) begin fail_count++; $display("[TB] FAIL rst_strobes: got %b expected 00", {mem_we, mem_re}); end
    if (mem_be !== 4'b0000) begin fail_count++; $display("[TB] FAIL rst_be: got %b expected 0000", mem_be); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    cmp_count += 5;
    if (mem_we !== 1'b1) begin fail_count++; $display("[TB] FAIL sw_we: got %b expected 1", mem_we); end
    if (mem_re !== 1'b0) begin fail_count++; $display("[TB] FAIL sw_re: got %b expected 0", mem_re); end
    if (mem_be !== 4'b1111) begin fail_count++; $display("[TB] FAIL sw_be: got %b expected 1111", mem_be); end
    if (mem_wdata !== 32'hDEADBEEF) begin fail_count++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", mem_wdata); end
    if (mem_addr !== 32'h100) begin fail_count++; $display("[TB] FAIL sw_addr: got %h expected 00000100", mem_addr); end
    step();
    cmp_count += 5;
    if (resp_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL sw_resp_valid: got %b expected 1", resp_valid); end
    if (resp_err !== 1'b0) begin fail_count++; $display("[TB] FAIL sw_resp_err: got %b expected 0", resp_err); end
    if (resp_rdata !== 32'h0) begin fail_count++; $display("[TB] FAIL sw_rdata: got %h expected 0", resp_rdata); end
    if (store_count !== 32'd1) begin fail_count++; $display("[TB] FAIL sw_store_count: got %0d expected 1", store_count); end
    if ({mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} !== 32'hDEADBEEF) begin
      fail_count++; $display("[TB] FAIL sw_mem: got %h expected deadbeef", {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]});
    end
    step();
    cmp_count++;
    if (req_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL sw_back_idle: got %b expected 1", req_ready); end
  endtask

  task automatic test_load_byte();
    issue(1'b1, 3'b000, 32'h200, 32'h00000080);
    step(); step();
    issue(1'b0, 3'b000, 32'h200, 32'h0);
    cmp_count += 3;
    if (mem_re !== 1'b1) begin fail_count++; $display("[TB] FAIL lb_re: got %b expected 1", mem_re); end
    if (mem_we !== 1'b0) begin fail_count++; $display("[TB] FAIL lb_we: got %b expected 0", mem_we); end
    if (mem_load_type !== 3'b000) begin fail_count++; $display("[TB] FAIL lb_type: got %b expected 000", mem_load_type); end
    step();
    cmp_count++;
    if (resp_rdata !== 32'hFFFFFF80) begin fail_count++; $display("[TB] FAIL lb_rdata: got %h expected ffffff80", resp_rdata); end
    step();
    issue(1'b0, 3'b100, 32'h200, 32'h0);
    cmp_count++;
    if (mem_load_type !== 3'b100) begin fail_count++; $display("[TB] FAIL lbu_type: got %b expected 100", mem_load_type); end
    step();
    cmp_count += 3;
    if (resp_rdata !== 32'h00000080) begin fail_count++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", resp_rdata); end
    if (load_count !== 32'd2) begin fail_count++; $display("[TB] FAIL lbu_load_count: got %0d expected 2", load_count); end
    if (store_count !== 32'd2) begin fail_count++; $display("[TB] FAIL lbu_store_count: got %0d expected 2", store_count); end
    step();
  endtask

  task automatic test_store_byte();
    issue(1'b1, 3'b000, 32'h301, 32'h12345678);
    cmp_count += 3;
    if (mem_be !== 4'b0001) begin fail_count++; $display("[TB] FAIL sb_be: got %b expected 0001", mem_be); end
    if (mem_wdata !== 32'h00000078) begin fail_count++; $display("[TB] FAIL sb_wdata: got %h expected 00000078", mem_wdata); end
    if (mem_addr !== 32'h301) begin fail_count++; $display("[TB] FAIL sb_addr: got %h expected 00000301", mem_addr); end
    step(); step();
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    step();
    cmp_count += 2;
    if (resp_rdata !== 32'h00007813) begin fail_count++; $display("[TB] FAIL lw_rdata: got %h expected 00007813", resp_rdata); end
    if (load_count !== 32'd3) begin fail_count++; $display("[TB] FAIL lw_load_count: got %0d expected 3", load_count); end
    step();
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    cmp_count += 5;
    if (resp_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL ill_ld_valid: got %b expected 1", resp_valid); end
    if (resp_err !== 1'b1) begin fail_count++; $display("[TB] FAIL ill_ld_err: got %b expected 1", resp_err); end
    if ({mem_re, mem_we} !== 2'b00) begin fail_count++; $display("[TB] FAIL ill_ld_strobe: got %b expected 00", {mem_re, mem_we}); end
    if (resp_rdata !== 32'h0) begin fail_count++; $display("[TB] FAIL ill_ld_rdata: got %h expected 0", resp_rdata); end
    if (load_count !== 32'd3) begin fail_count++; $display("[TB] FAIL ill_ld_count: got %0d expected 3", load_count); end
    step();
    issue(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);
    cmp_count += 3;
    if (resp_err !== 1'b1) begin fail_count++; $display("[TB] FAIL ill_st_err: got %b expected 1", resp_err); end
    if (mem_we !== 1'b0) begin fail_count++; $display("[TB] FAIL ill_st_we: got %b expected 0", mem_we); end
    if (store_count !== 32'd3) begin fail_count++; $display("[TB] FAIL ill_st_count: got %0d expected 3", store_count); end
    step();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    step();
    for (int c = 0; c < 5; c++) begin
      cmp_count += 3;
      if (resp_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", c, resp_valid); end
      if (resp_rdata !== 32'hDEADBEEF) begin fail_count++; $display("[TB] FAIL bp_rdata[%0d]: got %h expected deadbeef", c, resp_rdata); end
      if (req_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL bp_req_ready[%0d]: got %b expected 0", c, req_ready); end
      step();
    end
    resp_ready = 1'b1;
    step();
    cmp_count += 3;
    if (req_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL bp_release_ready: got %b expected 1", req_ready); end
    if (resp_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL bp_release_valid: got %b expected 0", resp_valid); end
    if (load_count !== 32'd4) begin fail_count++; $display("[TB] FAIL bp_load_count: got %0d expected 4", load_count); end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b1, 3'b010, 32'h100, 32'h11223344);
    cmp_count++;
    if (mem_we !== 1'b1) begin fail_count++; $display("[TB] FAIL rma_we_before: got %b expected 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    cmp_count += 5;
    if (mem_we !== 1'b0) begin fail_count++; $display("[TB] FAIL rma_we: got %b expected 0", mem_we); end
    if (mem_be !== 4'b0000) begin fail_count++; $display("[TB] FAIL rma_be: got %b expected 0000", mem_be); end
    if (resp_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL rma_valid: got %b expected 0", resp_valid); end
    if (store_count !== 32'd0) begin fail_count++; $display("[TB] FAIL rma_store_count: got %0d expected 0", store_count); end
    if (load_count !== 32'd0) begin fail_count++; $display("[TB] FAIL rma_load_count: got %0d expected 0", load_count); end
    step();
    cmp_count += 2;
    if ({mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} !== 32'hDEADBEEF) begin
      fail_count++; $display("[TB] FAIL rma_mem: got %h expected deadbeef", {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]});
    end
    if (req_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL rma_req_ready: got %b expected 1", req_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_misalign();
    issue(1'b0, 3'b001, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    cmp_count += 3;
    if (resp_err !== 1'b1) begin fail_count++; $display("[TB] FAIL mis_err: got %b expected 1", resp_err); end
    if (mem_re !== 1'b0) begin fail_count++; $display("[TB] FAIL mis_re: got %b expected 0", mem_re); end
    if (load_count !== 32'd0) begin fail_count++; $display("[TB] FAIL mis_count: got %0d expected 0", load_count); end
`else
    cmp_count++;
    if (mem_re !== 1'b1) begin fail_count++; $display("[TB] FAIL mis_re: got %b expected 1", mem_re); end
    step();
    cmp_count += 3;
    if (resp_err !== 1'b0) begin fail_count++; $display("[TB] FAIL mis_err: got %b expected 0", resp_err); end
    if (resp_rdata !== 32'hFFFFADBE) begin fail_count++; $display("[TB] FAIL mis_rdata: got %h expected ffffadbe", resp_rdata); end
    if (load_count !== 32'd1) begin fail_count++; $display("[TB] FAIL mis_count: got %0d expected 1", load_count); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_byte();
    test_illegal();
    test_backpressure();
    test_reset_mid_access();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
